// File: rtl/led_pkg.sv
// Shared types and constants for the LED pattern sequencer.
// LEDs are active-low throughout: a 0 bit is a lit LED.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_WATER  = 2'd0,
        MODE_BOUNCE = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_FILL   = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    localparam logic [5:0] SEED_WATER  = 6'b111110;
    localparam logic [5:0] SEED_BOUNCE = 6'b111110;
    localparam logic [5:0] SEED_BLINK  = 6'b000000;
    localparam logic [5:0] SEED_FILL   = 6'b111111;
    localparam logic [5:0] LED_OFF     = 6'b111111;

    function automatic logic [5:0] mode_seed(input mode_t m);
        logic [5:0] seed;
        unique case (m)
            MODE_WATER:  seed = SEED_WATER;
            MODE_BOUNCE: seed = SEED_BOUNCE;
            MODE_BLINK:  seed = SEED_BLINK;
            MODE_FILL:   seed = SEED_FILL;
        endcase
        return seed;
    endfunction

endpackage

// File: rtl/led_pattern_ctrl_key_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter, and a
// single-cycle press pulse on the accepted high-to-low transition.
module key_debounce
    import led_pkg::*;
#(
    parameter logic [19:0] DEB_CNT = 20'd1000000
) (
    input  logic clk,
    input  logic rstn,
    input  logic key_n,
    output logic press_o
);

    logic        sync1_reg;
    logic        sync2_reg;
    logic        level_reg;
    logic        press_reg;
    logic [19:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            level_reg <= 1'b1;
            press_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= key_n;
            sync2_reg <= sync1_reg;
            press_reg <= 1'b0;
            // Any sample agreeing with the accepted level restarts the count
            if (sync2_reg == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == DEB_CNT - 20'd1) begin
                cnt_reg   <= '0;
                level_reg <= sync2_reg;
                press_reg <= ~sync2_reg;
            end else begin
                cnt_reg <= cnt_reg + 20'd1;
            end
        end
    end

    assign press_o = press_reg;

endmodule

// File: rtl/led_pattern_ctrl.sv
// Six-LED pattern sequencer: speed-scaled prescaler, mode/speed registers
// driven by two debounced buttons, and the per-mode stepping logic.
module led_pattern_ctrl
    import led_pkg::*;
#(
    parameter logic [25:0] CNT_MAX = 26'd50000000,
    parameter logic [19:0] DEB_CNT = 20'd1000000,
    parameter int          LED_W   = 6
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             key_mode_n,
    input  logic             key_speed_n,
    input  logic             en,
    output logic [LED_W-1:0] led_o,
    output logic [1:0]       mode_o,
    output logic [1:0]       speed_o,
    output logic             tick_o
);

    logic        mode_press;
    logic        speed_press;
    logic [25:0] cnt_reg;
    logic [25:0] period;
    logic        tick;
    mode_t       mode_reg;
    mode_t       mode_next;
    logic [1:0]  speed_reg;
    logic [5:0]  led_reg;
    dir_t        dir_reg;
    logic [5:0]  step_led;
    dir_t        step_dir;
    logic [5:0]  lit;
    logic [5:0]  lit_next;

    key_debounce #(.DEB_CNT(DEB_CNT)) u_key_mode (
        .clk     (clk),
        .rstn    (rstn),
        .key_n   (key_mode_n),
        .press_o (mode_press)
    );

    key_debounce #(.DEB_CNT(DEB_CNT)) u_key_speed (
        .clk     (clk),
        .rstn    (rstn),
        .key_n   (key_speed_n),
        .press_o (speed_press)
    );

    assign period    = CNT_MAX >> speed_reg;
    assign tick      = en && (cnt_reg == period - 26'd1);
    assign mode_next = mode_t'(mode_reg + 2'd1);

    always_comb begin
        step_led = led_reg;
        step_dir = dir_reg;
        lit      = ~led_reg;
        lit_next = '0;
        unique case (mode_reg)
            MODE_WATER: begin
                step_led = (led_reg == LED_OFF) ? SEED_WATER : {led_reg[4:0], led_reg[5]};
            end
            MODE_BOUNCE: begin
                lit_next = (dir_reg == DIR_LEFT) ? (lit << 1) : (lit >> 1);
                // Reversal happens on the step that lands on an end bit
                if (lit_next == 6'd0) begin
                    step_led = SEED_BOUNCE;
                    step_dir = DIR_LEFT;
                end else begin
                    step_led = ~lit_next;
                    if (lit_next[5]) begin
                        step_dir = DIR_RIGHT;
                    end else if (lit_next[0]) begin
                        step_dir = DIR_LEFT;
                    end
                end
            end
            MODE_BLINK: begin
                step_led = ~led_reg;
            end
            MODE_FILL: begin
                step_led = (led_reg == 6'd0) ? LED_OFF : (led_reg & (led_reg - 6'd1));
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_reg   <= '0;
            mode_reg  <= MODE_WATER;
            speed_reg <= 2'd0;
            led_reg   <= LED_OFF;
            dir_reg   <= DIR_LEFT;
        end else begin
            if (mode_press || speed_press) begin
                cnt_reg <= '0;
            end else if (en) begin
                cnt_reg <= tick ? 26'd0 : cnt_reg + 26'd1;
            end
            if (speed_press) begin
                speed_reg <= speed_reg + 2'd1;
            end
            // A mode change reseeds at once and wins over a coincident step
            if (mode_press) begin
                mode_reg <= mode_next;
                led_reg  <= mode_seed(mode_next);
                dir_reg  <= DIR_LEFT;
            end else if (tick) begin
                led_reg <= step_led;
                dir_reg <= step_dir;
            end
        end
    end

    assign led_o   = led_reg;
    assign mode_o  = mode_reg;
    assign speed_o = speed_reg;
    assign tick_o  = tick;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Bench for led_pattern_ctrl with CNT_MAX=16, DEB_CNT=4: phase table of
// expected LED sequences fed through a scoreboard queue, plus corner cases.
module tb_led_pattern_ctrl;

    localparam logic [25:0] CNT_MAX = 26'd16;
    localparam logic [19:0] DEB_CNT = 20'd4;
    localparam logic [5:0]  Z       = 6'b000000;

    logic       clk = 1'b0;
    logic       rstn;
    logic       key_mode_n;
    logic       key_speed_n;
    logic       en;
    logic [5:0] led_o;
    logic [1:0] mode_o;
    logic [1:0] speed_o;
    logic       tick_o;

    always #5 clk = ~clk;

    led_pattern_ctrl #(.CNT_MAX(CNT_MAX), .DEB_CNT(DEB_CNT), .LED_W(6)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .key_mode_n  (key_mode_n),
        .key_speed_n (key_speed_n),
        .en          (en),
        .led_o       (led_o),
        .mode_o      (mode_o),
        .speed_o     (speed_o),
        .tick_o      (tick_o)
    );

    typedef struct {
        int               mode_presses;
        int               speed_presses;
        logic [1:0]       exp_mode;
        logic [1:0]       exp_speed;
        logic             chk_start;
        logic [5:0]       start;
        int               gap;
        int               n;
        logic [0:11][5:0] seq;
    } phase_t;

    phase_t     ph [9];
    int         n_cmp = 0;
    int         n_err = 0;
    logic [5:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0b, expected %0b", name, act, want);
        end
    endtask

    task automatic press(input logic do_mode, input logic do_speed, input int hold);
        @(negedge clk);
        if (do_mode)  key_mode_n  = 1'b0;
        if (do_speed) key_speed_n = 1'b0;
        repeat (hold) @(negedge clk);
        key_mode_n  = 1'b1;
        key_speed_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    // Called at a negedge where the prescaler sits at 0; the gap counted is
    // the number of negedges until tick_o, i.e. period-1.
    task automatic step_check(input string name, input int exp_gap);
        int         n;
        logic [5:0] e;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick_o && n < 100);
        check({name, " gap"}, n, exp_gap);
        @(negedge clk);
        check({name, " pulse"}, {31'd0, tick_o}, 0);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: scoreboard empty, led got %b", name, led_o);
        end else begin
            e = exp_q.pop_front();
            check({name, " led"}, {26'd0, led_o}, {26'd0, e});
            $display("tick %s gap=%0d led=%b expected=%b", name, n, led_o, e);
        end
    endtask

    task automatic run_phase(input int p);
        en = 1'b0;
        repeat (ph[p].mode_presses)  press(1'b1, 1'b0, 8);
        repeat (ph[p].speed_presses) press(1'b0, 1'b1, 8);
        check($sformatf("ph%0d mode", p), {30'd0, mode_o}, {30'd0, ph[p].exp_mode});
        check($sformatf("ph%0d speed", p), {30'd0, speed_o}, {30'd0, ph[p].exp_speed});
        if (ph[p].chk_start)
            check($sformatf("ph%0d seed", p), {26'd0, led_o}, {26'd0, ph[p].start});
        for (int i = 0; i < ph[p].n; i++) exp_q.push_back(ph[p].seq[i]);
        en = 1'b1;
        for (int i = 0; i < ph[p].n; i++) step_check($sformatf("ph%0d.%0d", p, i), ph[p].gap);
        en = 1'b0;
    endtask

    initial begin
        logic [5:0] saved;
        logic       frozen;

        ph[0] = '{0, 0, 2'd0, 2'd0, 1'b0, Z, 15, 7,
                  {6'b111110, 6'b111101, 6'b111011, 6'b110111, 6'b101111, 6'b011111,
                   6'b111110, Z, Z, Z, Z, Z}};
        ph[1] = '{0, 1, 2'd0, 2'd1, 1'b0, Z, 7, 2,
                  {6'b111101, 6'b111011, Z, Z, Z, Z, Z, Z, Z, Z, Z, Z}};
        ph[2] = '{0, 1, 2'd0, 2'd2, 1'b0, Z, 3, 2,
                  {6'b110111, 6'b101111, Z, Z, Z, Z, Z, Z, Z, Z, Z, Z}};
        ph[3] = '{0, 1, 2'd0, 2'd3, 1'b0, Z, 1, 2,
                  {6'b011111, 6'b111110, Z, Z, Z, Z, Z, Z, Z, Z, Z, Z}};
        ph[4] = '{0, 1, 2'd0, 2'd0, 1'b0, Z, 15, 1,
                  {6'b111101, Z, Z, Z, Z, Z, Z, Z, Z, Z, Z, Z}};
        ph[5] = '{1, 0, 2'd1, 2'd0, 1'b1, 6'b111110, 15, 11,
                  {6'b111101, 6'b111011, 6'b110111, 6'b101111, 6'b011111, 6'b101111,
                   6'b110111, 6'b111011, 6'b111101, 6'b111110, 6'b111101, Z}};
        ph[6] = '{1, 0, 2'd2, 2'd0, 1'b1, 6'b000000, 15, 4,
                  {6'b111111, 6'b000000, 6'b111111, 6'b000000, Z, Z, Z, Z, Z, Z, Z, Z}};
        ph[7] = '{1, 0, 2'd3, 2'd0, 1'b1, 6'b111111, 15, 8,
                  {6'b111110, 6'b111100, 6'b111000, 6'b110000, 6'b100000, 6'b000000,
                   6'b111111, 6'b111110, Z, Z, Z, Z}};
        ph[8] = '{1, 0, 2'd0, 2'd0, 1'b1, 6'b111110, 15, 2,
                  {6'b111101, 6'b111011, Z, Z, Z, Z, Z, Z, Z, Z, Z, Z}};

        rstn        = 1'b0;
        key_mode_n  = 1'b1;
        key_speed_n = 1'b1;
        en          = 1'b0;
        repeat (3) @(negedge clk);
        check("reset led", {26'd0, led_o}, 32'b111111);
        check("reset mode", {30'd0, mode_o}, 0);
        check("reset speed", {30'd0, speed_o}, 0);
        check("reset tick", {31'd0, tick_o}, 0);
        rstn = 1'b1;

        for (int p = 0; p < 5; p++) run_phase(p);

        // Two-cycle glitch on the speed key must be rejected
        @(negedge clk);
        key_speed_n = 1'b0;
        repeat (2) @(negedge clk);
        key_speed_n = 1'b1;
        repeat (10) @(negedge clk);
        check("glitch speed", {30'd0, speed_o}, 0);
        check("glitch led", {26'd0, led_o}, 32'b111101);

        for (int p = 5; p < 9; p++) run_phase(p);

        // Freeze mid-count in WATER, then resume with the remaining count
        exp_q.push_back(6'b110111);
        en = 1'b1;
        step_check("pre_freeze", 15);
        repeat (5) @(negedge clk);
        en     = 1'b0;
        saved  = led_o;
        frozen = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (tick_o !== 1'b0 || led_o !== saved) frozen = 1'b0;
        end
        check("freeze hold", {31'd0, frozen}, 1);
        exp_q.push_back(6'b101111);
        en = 1'b1;
        step_check("resume", 10);
        en = 1'b0;

        // Both keys in the same cycle
        press(1'b1, 1'b1, 8);
        check("both mode", {30'd0, mode_o}, 1);
        check("both speed", {30'd0, speed_o}, 1);
        check("both seed", {26'd0, led_o}, 32'b111110);
        exp_q.push_back(6'b111101);
        en = 1'b1;
        step_check("both", 7);
        en = 1'b0;

        // Reach FILL at speed 2, step once, then reset with en and a key active
        press(1'b1, 1'b0, 8);
        press(1'b1, 1'b0, 8);
        press(1'b0, 1'b1, 8);
        check("pre_rst mode", {30'd0, mode_o}, 3);
        check("pre_rst speed", {30'd0, speed_o}, 2);
        check("pre_rst seed", {26'd0, led_o}, 32'b111111);
        exp_q.push_back(6'b111110);
        en = 1'b1;
        step_check("fill", 3);
        rstn       = 1'b0;
        key_mode_n = 1'b0;
        @(negedge clk);
        check("midrst led", {26'd0, led_o}, 32'b111111);
        check("midrst mode", {30'd0, mode_o}, 0);
        check("midrst speed", {30'd0, speed_o}, 0);
        check("midrst tick", {31'd0, tick_o}, 0);
        rstn       = 1'b1;
        key_mode_n = 1'b1;
        exp_q.push_back(6'b111110);
        step_check("post_rst", 15);
        check("post_rst mode", {30'd0, mode_o}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
